// File: rtl/console_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : console_uart_tx
//  Purpose  : Sink for the core's memory-mapped console write port. Each
//             console_we strobe queues console_wdata[7:0] in a small FIFO,
//             and an 8N1 UART transmitter drains the FIFO onto tx.
//  Ports    : clk           - system clock, rising-edge
//             reset         - asynchronous active-low reset
//             console_we    - one-cycle write strobe from the core
//             console_wdata - write data, only [7:0] is transmitted
//             tx            - UART serial line, idles high (registered)
//             busy          - frame in flight or FIFO non-empty
//             overflow      - sticky: a write was dropped on a full FIFO
//             level         - current FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module console_uart_tx #(
    parameter int XLEN         = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          console_we,
    input  logic [XLEN-1:0]               console_wdata,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_lvl_w-1:0] c_full     = c_lvl_w'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 r_overflow;
    logic [c_lvl_w-1:0]   r_level;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [7:0]           r_mem [FIFO_DEPTH];

    logic                 w_last;
    logic                 w_pop;
    logic                 w_push;
    logic [7:0]           w_head;
    logic                 w_unused_wdata;

    // Upper write-data bits are deliberately ignored.
    assign w_unused_wdata = ^{1'b0, console_wdata};

    assign w_last = (r_cnt == c_cnt_last);
    assign w_head = r_mem[r_rd_ptr];

    // A pop only ever happens when the transmitter is ready to start a
    // frame: from IDLE, or at the final stop-bit cycle for back-to-back
    // frames with no idle gap.
    assign w_pop  = (r_level != '0) &&
                    ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last));

    // A full FIFO still accepts a write when a pop frees a slot at the same
    // edge. The head is read before the write lands, so the popped byte is
    // the old one even when both pointers coincide.
    assign w_push = console_we && ((r_level != c_full) || w_pop);

    // FIFO storage: no reset needed, validity is tracked by the level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= console_wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (console_we && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Transmit FSM. tx is registered and only changes at bit boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // Next bit is the one about to shift into [0].
                            r_bit <= r_bit + 1'b1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign overflow = r_overflow;
    assign level    = r_level;
    // Derived only from registers, so there is no path from console_we.
    assign busy     = (r_state != S_IDLE) || (r_level != '0);

endmodule
`default_nettype wire

// File: tb/tb_console_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_console_uart_tx
//  Purpose  : Self-checking bench for console_uart_tx (CLKS_PER_BIT=4,
//             FIFO_DEPTH=4). Writes push expected bytes into a queue; a UART
//             receiver process decodes frames on tx and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_console_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            console_we = 1'b0;
    logic [XLEN-1:0] console_wdata = '0;
    logic            tx;
    logic            busy;
    logic            overflow;
    logic [2:0]      level;

    console_uart_tx #(
        .XLEN         (XLEN),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .console_we    (console_we),
        .console_wdata (console_wdata),
        .tx            (tx),
        .busy          (busy),
        .overflow      (overflow),
        .level         (level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One write strobe, sampled at the next rising edge; returns 1ns after it.
    task automatic write(input logic [31:0] d, input bit accept);
        console_we    = 1'b1;
        console_wdata = d;
        @(posedge clk);
        #1;
        console_we    = 1'b0;
        console_wdata = '0;
        if (accept) exp_q.push_back(d[7:0]);
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (cyc != target && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_cycle_bound", 32'(n < 5000), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 3000), 32'd1);
        repeat (3) @(negedge clk);
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    // UART receiver: detects the start bit, samples each bit mid-way and
    // scores the decoded byte against the head of the expected queue.
    bit         m_abort;
    bit         m_busy_ok;
    logic [9:0] m_bits;
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                starts.push_back(cyc);
                m_abort   = 1'b0;
                m_busy_ok = 1'b1;
                m_bits    = '0;
                for (int j = 1; j <= 38; j++) begin
                    @(negedge clk);
                    if (reset !== 1'b1) m_abort = 1'b1;
                    if (!m_abort && j >= 2 && ((j - 2) % CPB) == 0) begin
                        m_bits[(j - 2) / CPB] = tx;
                        if (busy !== 1'b1) m_busy_ok = 1'b0;
                    end
                end
                if (!m_abort) begin
                    check("start_bit", 32'(m_bits[0]), 32'd0);
                    check("stop_bit", 32'(m_bits[9]), 32'd1);
                    check("busy_in_frame", 32'(m_busy_ok), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'(m_bits[8:1]), 32'hFFFF);
                    end else begin
                        check("frame_byte", 32'(m_bits[8:1]), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0;
        int  s0;
        bit  quiet;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single write 0x41, start bit at the edge after the write
        s0 = starts.size();
        write(32'h41, 1'b1);
        c0 = cyc;
        check("t1_level", 32'(level), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        wait_idle();
        check("t1_start_latency", 32'(starts[s0]), 32'(c0 + 1));

        // Upper data bits ignored
        write(32'hDEADBE55, 1'b1);
        wait_idle();

        // Back-to-back frames, no idle gap
        s0 = starts.size();
        write(32'h12, 1'b1);
        c0 = cyc;
        check("t3_level_a", 32'(level), 32'd1);
        write(32'h34, 1'b1);
        check("t3_level_b", 32'(level), 32'd1);
        wait_cyc(c0 + 40);
        check("t3_level_before_pop", 32'(level), 32'd1);
        check("t3_stop_tx", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        check("t3_level_after_pop", 32'(level), 32'd0);
        check("t3_second_start_tx", 32'(tx), 32'd0);
        wait_idle();
        check("t3_gap", 32'(starts[s0 + 1] - starts[s0]), 32'd40);

        // Overflow: six writes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) begin
            write(32'hA0 + 32'(i), i < 5);
            if (i == 4) check("t4_no_overflow_yet", 32'(overflow), 32'd0);
        end
        check("t4_level_full", 32'(level), 32'd4);
        check("t4_overflow", 32'(overflow), 32'd1);
        wait_idle();
        check("t4_overflow_sticky", 32'(overflow), 32'd1);
        check("t4_level_drained", 32'(level), 32'd0);

        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst2_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;

        // Full FIFO, write coincides with the stop-bit pop
        for (int i = 0; i < 5; i++) begin
            write(32'hB0 + 32'(i), 1'b1);
            if (i == 0) c0 = cyc;
        end
        check("t5_level_full", 32'(level), 32'd4);
        wait_cyc(c0 + 40);
        check("t5_level_before", 32'(level), 32'd4);
        write(32'hB5, 1'b1);
        check("t5_level_after", 32'(level), 32'd4);
        check("t5_overflow", 32'(overflow), 32'd0);
        check("t5_next_start", 32'(tx), 32'd0);
        wait_idle();

        // Asynchronous reset during data bit 3 (0xF0: bit 3 is 0)
        write(32'hF0, 1'b1);
        c0 = cyc;
        write(32'hC1, 1'b1);
        write(32'hC2, 1'b1);
        wait_cyc(c0 + 18);
        check("t6_bit3_tx", 32'(tx), 32'd0);
        check("t6_level", 32'(level), 32'd2);
        reset = 1'b0;
        #1;
        check("t6_async_tx", 32'(tx), 32'd1);
        check("t6_level_clr", 32'(level), 32'd0);
        check("t6_busy_clr", 32'(busy), 32'd0);
        check("t6_overflow_clr", 32'(overflow), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        s0 = starts.size();
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check("t6_quiet_after_reset", 32'(quiet), 32'd1);
        check("t6_no_new_frames", 32'(starts.size()), 32'(s0));
        write(32'h5A, 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
